message_word_sender: RTL and testbench
======================================

// Module: message_word_sender
// PURPOSE
// - Transmit-side counterpart of the single-word message receiver: frames one data word as an outbound message
//   and streams it byte-by-byte to the byte transmitter (UART TX) toward the Arduino.
// - Frame = SYNC, MSG_ID, BYTE_COUNT, then BytesPerWord data bytes, least-significant byte first.
// - Sits between application logic (presents word + Send) and the shared byte transmitter.
// PARAMETERS
// - BytesPerWord  4      data bytes per word; legal 1..16; DataWord width = 8*BytesPerWord
// - MsgId         8'h01  message identifier byte placed in the header
// PORTS
// - Clock      in   1               system clock; all state updates on posedge
// - Clear_n    in   1               asynchronous, active-low reset
// - Send       in   1               request: latch DataWord and start a frame (honoured only when idle)
// - DataWord   in   8*BytesPerWord  word to transmit; sampled on the accepted Send cycle only
// - Busy       out  1               high from the cycle after accepted Send until Done
// - Done       out  1               one-cycle pulse after the last byte is accepted
// - TxByte     out  8               byte presented to the transmitter
// - TxValid    out  1               TxByte is valid
// - TxReady    in   1               transmitter can accept; a byte transfers on posedge when TxValid & TxReady
// BEHAVIOUR
// - Reset (Clear_n low, async): state IDLE; Busy=0, Done=0, TxValid=0, TxByte=8'h00; latched word = 0; byte index = 0.
// - FSM: IDLE -> SYNC -> ID -> COUNT -> DATA -> DONE -> IDLE.
//   - IDLE:  Send=1 latches DataWord and goes to SYNC next cycle; Send while not IDLE is ignored (no queueing).
//   - SYNC/ID/COUNT: TxValid=1, TxByte = SYNC_BYTE (8'hA5) / MsgId / BytesPerWord; advance on transfer.
//   - DATA:  TxByte = word[8*i+7 -: 8], i = 0..BytesPerWord-1; i increments per transfer; leave after i=BytesPerWord-1.
//   - DONE:  TxValid=0, Done=1 for exactly one cycle, Busy=0 in the same cycle; returns to IDLE.
// - Handshake: TxValid, once asserted, stays high and TxByte stays stable until transferred (no retraction).
//   TxValid never depends combinationally on TxReady (registered outputs).
// - Latency: Send accepted at cycle N -> TxValid=1 with SYNC at N+1. With TxReady held high, one byte per cycle;
//   last data byte transfers at N+3+BytesPerWord, Done at N+4+BytesPerWord.
// - Stalls: TxReady low holds current state/byte indefinitely; no timeout.
// - Word stability: DataWord changes after acceptance do not affect the frame in flight.
// - Back-to-back: Send asserted in the DONE cycle is ignored; Send one cycle later (IDLE) is accepted.
// - Reset mid-frame: frame is abandoned immediately, TxValid drops asynchronously; no partial resume.
// - Byte index width = $clog2(BytesPerWord) (min 1); wraps to 0 on entering DATA; never exceeds BytesPerWord-1.
// STRUCTURE
// - Shared package arduino_msg_pkg: SYNC_BYTE (8'hA5), HEADER_BYTES (3), message-ID constants,
//   tx-state enum (IDLE, SYNC, ID, COUNT, DATA, DONE).
// - Single module; one natural sub-module: word_byte_mux (latched word + index -> selected byte),
//   reusable by multi-word senders.
// TESTING
// - Reset: Clear_n low mid-DATA -> TxValid=0, Busy=0, Done=0 immediately; next Send produces a full fresh frame.
// - Basic frame, BytesPerWord=4, MsgId=8'h01, TxReady=1, DataWord=32'h12345678, Send pulse
//   -> bytes A5,01,04,78,56,34,12 on consecutive cycles; Done one cycle after 12.
// - Backpressure: same word, TxReady toggled 1,0,0,1,... -> identical byte sequence; TxByte stable while TxReady=0.
// - Send while Busy with DataWord=32'hDEADBEEF -> ignored; original frame unchanged; no second frame.
// - DataWord changed after accept -> frame still carries the latched value.
// - BytesPerWord=1, DataWord=8'h3C -> A5,01,01,3C; Done exactly 5 cycles after accept (TxReady=1).

Source files
------------

// File: rtl/arduino_msg_pkg.sv
// Shared constants and types for the Arduino message framing blocks.
// Header layout is SYNC, MSG_ID, BYTE_COUNT, followed by the payload bytes.
package arduino_msg_pkg;

   localparam logic [7:0]  SYNC_BYTE    = 8'hA5;
   localparam int unsigned HEADER_BYTES = 32'd3;
   localparam logic [7:0]  MSG_ID_WORD  = 8'h01;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SYNC  = 3'd1,
      ID    = 3'd2,
      COUNT = 3'd3,
      DATA  = 3'd4,
      DONE  = 3'd5
   } tx_state_t;

   // Byte-index width for an n-byte word; a single-byte word still gets one bit
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 32'd1) ? $clog2(n) : 32'd1;
   endfunction

endpackage

// File: rtl/message_word_sender_if.sv
// Application-side request/status and byte-transmitter handshake of the word sender.
interface message_word_sender_if #(
   parameter int unsigned BytesPerWord = 4
);
   logic                      Send;
   logic [8*BytesPerWord-1:0] DataWord;
   logic                      Busy;
   logic                      Done;
   logic [7:0]                TxByte;
   logic                      TxValid;
   logic                      TxReady;

   modport master (
      output Send, DataWord, TxReady,
      input  Busy, Done, TxByte, TxValid
   );

   modport slave (
      input  Send, DataWord, TxReady,
      output Busy, Done, TxByte, TxValid
   );
endinterface

// File: rtl/message_word_sender_word_byte_mux.sv
// Selects one byte of a latched word by index (byte 0 = least significant).
module word_byte_mux
   import arduino_msg_pkg::*;
#(
   parameter int unsigned BytesPerWord = 4,
   parameter int unsigned IdxW         = idx_width(BytesPerWord)
) (
   input  logic [8*BytesPerWord-1:0] word,
   input  logic [IdxW-1:0]           idx,
   output logic [7:0]                sel_byte
);

   // Priority-free select; indices past the word return 8'h00
   always_comb begin
      sel_byte = 8'h00;
      for (int i = 0; i < int'(BytesPerWord); i++) begin
         sel_byte = (idx == IdxW'(i)) ? word[8*i +: 8] : sel_byte;
      end
   end

endmodule

// File: rtl/message_word_sender.sv
// Frames one data word as SYNC, MSG_ID, BYTE_COUNT, payload (LSB first) and
// streams it to a byte transmitter with a valid/ready handshake.
module message_word_sender
   import arduino_msg_pkg::*;
#(
   parameter int unsigned BytesPerWord = 4,
   parameter logic [7:0]  MsgId        = MSG_ID_WORD
) (
   input logic                  Clock,
   input logic                  Clear_n,
   message_word_sender_if.slave bus
);

   localparam int unsigned      IDX_W    = idx_width(BytesPerWord);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BytesPerWord - 32'd1);

   tx_state_t                 state;
   tx_state_t                 state_next;
   logic [8*BytesPerWord-1:0] word;
   logic [8*BytesPerWord-1:0] word_next;
   logic [IDX_W-1:0]          idx;
   logic [IDX_W-1:0]          idx_next;
   logic [7:0]                data_byte;
   logic [7:0]                tx_byte_next;
   logic                      tx_valid_next;
   logic                      done_next;
   logic                      xfer;

   assign xfer = bus.TxValid & bus.TxReady;

   // Outputs are computed from the next state so that they register in step with it
   word_byte_mux #(
      .BytesPerWord (BytesPerWord),
      .IdxW         (IDX_W)
   ) u_byte_mux (
      .word     (word_next),
      .idx      (idx_next),
      .sel_byte (data_byte)
   );

   // Next-state, latched word, byte index and next output values
   always_comb begin
      state_next = state;
      word_next  = word;
      idx_next   = idx;
      case (state)
         IDLE: begin
            if (bus.Send) begin
               state_next = SYNC;
               word_next  = bus.DataWord;
               idx_next   = '0;
            end else begin
               state_next = IDLE;
            end
         end
         SYNC: begin
            if (xfer) state_next = ID;
            else      state_next = SYNC;
         end
         ID: begin
            if (xfer) state_next = COUNT;
            else      state_next = ID;
         end
         COUNT: begin
            if (xfer) begin
               state_next = DATA;
               idx_next   = '0;
            end else begin
               state_next = COUNT;
            end
         end
         DATA: begin
            if (xfer && (idx == LAST_IDX)) begin
               state_next = DONE;
            end else if (xfer) begin
               idx_next = idx + IDX_W'(1);
            end else begin
               state_next = DATA;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase

      tx_valid_next = (state_next == SYNC) || (state_next == ID) ||
                      (state_next == COUNT) || (state_next == DATA);
      done_next     = (state_next == DONE);

      case (state_next)
         SYNC:    tx_byte_next = SYNC_BYTE;
         ID:      tx_byte_next = MsgId;
         COUNT:   tx_byte_next = 8'(BytesPerWord);
         DATA:    tx_byte_next = data_byte;
         default: tx_byte_next = 8'h00;
      endcase
   end

   // State, latched word, byte index and registered outputs
   always_ff @(posedge Clock or negedge Clear_n) begin
      if (!Clear_n) begin
         state       <= IDLE;
         word        <= '0;
         idx         <= '0;
         bus.Busy    <= 1'b0;
         bus.Done    <= 1'b0;
         bus.TxValid <= 1'b0;
         bus.TxByte  <= 8'h00;
      end else begin
         state       <= state_next;
         word        <= word_next;
         idx         <= idx_next;
         bus.Busy    <= tx_valid_next;
         bus.Done    <= done_next;
         bus.TxValid <= tx_valid_next;
         bus.TxByte  <= tx_byte_next;
      end
   end

endmodule

// File: tb/tb_message_word_sender.sv
// Scoreboard bench for message_word_sender: a 4-byte and a 1-byte instance.
module tb_message_word_sender;
   import arduino_msg_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   message_word_sender_if #(.BytesPerWord(4)) bus4 ();
   message_word_sender_if #(.BytesPerWord(1)) bus1 ();

   message_word_sender #(.BytesPerWord(4), .MsgId(8'h01)) dut4 (
      .Clock   (clk),
      .Clear_n (rst_n),
      .bus     (bus4)
   );

   message_word_sender #(.BytesPerWord(1), .MsgId(8'h01)) dut1 (
      .Clock   (clk),
      .Clear_n (rst_n),
      .bus     (bus1)
   );

   int         checks = 0;
   int         errors = 0;
   int         done4  = 0;
   int         done1  = 0;
   logic [7:0] exp_q4[$];
   logic [7:0] exp_q1[$];
   logic       stalled4 = 1'b0;
   logic [7:0] stall_byte4 = 8'h00;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // 4-byte instance: pop on every transfer, hold byte steady while stalled
   always @(negedge clk) begin
      if (rst_n) begin
         if (stalled4) begin
            check_eq("no_retract4", 32'(bus4.TxValid), 32'd1);
            check_eq("stall_hold4", 32'(bus4.TxByte), 32'(stall_byte4));
         end
         if (bus4.TxValid && bus4.TxReady) begin
            check_eq("queue_has_entry4", 32'(exp_q4.size() != 0), 32'd1);
            if (exp_q4.size() != 0) check_eq("byte4", 32'(bus4.TxByte), 32'(exp_q4.pop_front()));
            stalled4 <= 1'b0;
         end else if (bus4.TxValid) begin
            stalled4    <= 1'b1;
            stall_byte4 <= bus4.TxByte;
         end else begin
            stalled4 <= 1'b0;
         end
         if (bus4.Done) done4 <= done4 + 1;
      end else begin
         stalled4 <= 1'b0;
      end
   end

   // 1-byte instance scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus1.TxValid && bus1.TxReady) begin
            check_eq("queue_has_entry1", 32'(exp_q1.size() != 0), 32'd1);
            if (exp_q1.size() != 0) check_eq("byte1", 32'(bus1.TxByte), 32'(exp_q1.pop_front()));
         end
         if (bus1.Done) done1 <= done1 + 1;
      end
   end

   task automatic push_frame4(input logic [31:0] w);
      exp_q4.push_back(SYNC_BYTE);
      exp_q4.push_back(8'h01);
      exp_q4.push_back(8'h04);
      for (int b = 0; b < 4; b++) exp_q4.push_back(w[8*b +: 8]);
   endtask

   // Present a word for one cycle; returns one step into the cycle after acceptance
   task automatic send4(input logic [31:0] w);
      @(posedge clk); #1;
      bus4.Send     = 1'b1;
      bus4.DataWord = w;
      push_frame4(w);
      @(posedge clk); #1;
      bus4.Send     = 1'b0;
      bus4.DataWord = ~w;
   endtask

   // Wait (bounded) for Done; exp_cycles = 0 means only require that it arrives
   task automatic wait_done(input string tag, input bit sel1, input int exp_cycles,
                            input bit toggle, input bit inject);
      int         k;
      logic [3:0] pat;
      k   = 0;
      pat = 4'b1001;
      for (int i = 1; i <= 200 && k == 0; i++) begin
         @(negedge clk);
         if (i == 1) begin
            check_eq({tag, "_first_valid"}, 32'(sel1 ? bus1.TxValid : bus4.TxValid), 32'd1);
            check_eq({tag, "_first_sync"}, 32'(sel1 ? bus1.TxByte : bus4.TxByte), 32'(SYNC_BYTE));
         end
         if (sel1 ? bus1.Done : bus4.Done) begin
            k = i;
            check_eq({tag, "_busy_at_done"}, 32'(sel1 ? bus1.Busy : bus4.Busy), 32'd0);
            check_eq({tag, "_valid_at_done"}, 32'(sel1 ? bus1.TxValid : bus4.TxValid), 32'd0);
         end else begin
            @(posedge clk); #1;
            if (toggle) bus4.TxReady = pat[2'(i % 4)];
            if (inject && i == 3) begin
               bus4.Send     = 1'b1;
               bus4.DataWord = 32'hDEADBEEF;
            end else if (inject && i == 4) begin
               bus4.Send = 1'b0;
            end
         end
      end
      if (exp_cycles > 0) check_eq({tag, "_latency"}, 32'(k), 32'(exp_cycles));
      else                check_eq({tag, "_done_seen"}, 32'(k != 0), 32'd1);
      check_eq({tag, "_queue_empty"}, 32'(sel1 ? exp_q1.size() : exp_q4.size()), 32'd0);
      bus4.TxReady = 1'b1;
   endtask

   initial begin
      rst_n         = 1'b0;
      bus4.Send     = 1'b0;
      bus4.DataWord = 32'h0;
      bus4.TxReady  = 1'b1;
      bus1.Send     = 1'b0;
      bus1.DataWord = 8'h00;
      bus1.TxReady  = 1'b1;

      // Reset state
      #22;
      check_eq("rst_valid", 32'(bus4.TxValid), 32'd0);
      check_eq("rst_busy", 32'(bus4.Busy), 32'd0);
      check_eq("rst_done", 32'(bus4.Done), 32'd0);
      check_eq("rst_byte", 32'(bus4.TxByte), 32'h00);
      check_eq("rst_valid1", 32'(bus1.TxValid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("idle_valid", 32'(bus4.TxValid), 32'd0);

      // Basic frame with TxReady held high
      send4(32'h12345678);
      wait_done("basic", 1'b0, int'(HEADER_BYTES) + 4 + 1, 1'b0, 1'b0);
      @(negedge clk);
      check_eq("done_one_cycle", 32'(bus4.Done), 32'd0);

      // Backpressure plus an ignored Send while busy
      send4(32'h12345678);
      wait_done("bp", 1'b0, 0, 1'b1, 1'b1);
      repeat (10) @(negedge clk);
      check_eq("no_second_frame", 32'(bus4.TxValid), 32'd0);

      // Back-to-back: Send in the DONE cycle ignored, next cycle accepted
      send4(32'h12345678);
      repeat (7) @(posedge clk);
      #1;
      check_eq("b2b_done", 32'(bus4.Done), 32'd1);
      check_eq("b2b_busy", 32'(bus4.Busy), 32'd0);
      check_eq("b2b_queue", 32'(exp_q4.size()), 32'd0);
      bus4.Send     = 1'b1;
      bus4.DataWord = 32'h0BADF00D;
      @(posedge clk); #1;
      check_eq("b2b_idle_valid", 32'(bus4.TxValid), 32'd0);
      bus4.DataWord = 32'h55AA33CC;
      push_frame4(32'h55AA33CC);
      @(posedge clk); #1;
      bus4.Send     = 1'b0;
      bus4.DataWord = 32'h0;
      wait_done("b2b", 1'b0, int'(HEADER_BYTES) + 4 + 1, 1'b0, 1'b0);

      // Reset in the middle of the payload, then a fresh frame
      send4(32'hA1B2C3D4);
      repeat (4) @(posedge clk);
      #1;
      check_eq("mid_valid", 32'(bus4.TxValid), 32'd1);
      check_eq("mid_byte", 32'(bus4.TxByte), 32'hC3);
      rst_n = 1'b0;
      #1;
      check_eq("async_valid", 32'(bus4.TxValid), 32'd0);
      check_eq("async_busy", 32'(bus4.Busy), 32'd0);
      check_eq("async_done", 32'(bus4.Done), 32'd0);
      exp_q4.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send4(32'h0F1E2D3C);
      wait_done("fresh", 1'b0, int'(HEADER_BYTES) + 4 + 1, 1'b0, 1'b0);

      // Single-byte word
      @(posedge clk); #1;
      bus1.Send     = 1'b1;
      bus1.DataWord = 8'h3C;
      exp_q1.push_back(SYNC_BYTE);
      exp_q1.push_back(8'h01);
      exp_q1.push_back(8'h01);
      exp_q1.push_back(8'h3C);
      @(posedge clk); #1;
      bus1.Send     = 1'b0;
      bus1.DataWord = 8'hC3;
      wait_done("bpw1", 1'b1, int'(HEADER_BYTES) + 1 + 1, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      check_eq("done_count4", 32'(done4), 32'd5);
      check_eq("done_count1", 32'(done1), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
